neuron: RTL



---
 rtl/neuron_if.sv | 32 +++
 rtl/neuron.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_if.sv
// Handshake bundle between the neuron and its neighbours in the datapath.
// inp: activations in, arg: weighted sum out, dlt: training delta in.
// The slave modport is the neuron's view; master is the surrounding datapath.
interface neuron_if;
    logic        inp_stb;
    logic [7:0]  inp_dat;
    logic        inp_rdy;
    logic        arg_stb;
    logic [15:0] arg_dat;
    logic        arg_rdy;
    logic        dlt_stb;
    logic [15:0] dlt_dat;
    logic        dlt_rdy;

    modport master (
        output inp_stb, inp_dat,
        input  inp_rdy,
        input  arg_stb, arg_dat,
        output arg_rdy,
        output dlt_stb, dlt_dat,
        input  dlt_rdy
    );

    modport slave (
        input  inp_stb, inp_dat,
        output inp_rdy,
        output arg_stb, arg_dat,
        input  arg_rdy,
        input  dlt_stb, dlt_dat,
        output dlt_rdy
    );
endinterface

// File: rtl/neuron.sv
// Single trainable neuron: collects N unsigned Q0.8 activations, accumulates
// bias + sum(w*x), presents the Q8.8 sum downstream and, when training is
// enabled, takes a Q8.8 delta back and updates weights and bias in place.
// Optional macro NEURON_SATURATE_EN: clamp the output and weight/bias updates
// to the signed 16-bit range instead of wrapping.
module neuron #(
    parameter int unsigned N    = 2,
    parameter int unsigned RATE = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     en_i,
    neuron_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(N + 1);
    localparam int unsigned AdrW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [IdxW-1:0] BiasIdx = IdxW'(N);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    localparam logic [1:0] StIn  = 2'd0;
    localparam logic [1:0] StArg = 2'd1;
    localparam logic [1:0] StDlt = 2'd2;
    localparam logic [1:0] StUpd = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic signed [31:0]  acc_q, acc_d;
    logic signed [15:0]  w_q [N];
    logic signed [15:0]  w_d [N];
    logic signed [15:0]  b_q, b_d;
    logic [7:0]          x_q [N];
    logic [7:0]          x_d [N];
    logic signed [15:0]  dlt_q, dlt_d;

    // Clamp (or wrap) an 18-bit update sum back into a Q8.8 word.
    function automatic logic signed [15:0] upd_fn(input logic signed [17:0] s);
`ifdef NEURON_SATURATE_EN
        if (s > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (s < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return s[15:0];
        end
`else
        return s[15:0];
`endif
    endfunction

    // Index into the N-entry arrays; only meaningful while idx_q < N.
    logic [AdrW-1:0] adr;
    assign adr = idx_q[AdrW-1:0];

    logic inp_ack, arg_ack, dlt_ack;
    assign inp_ack = bus.inp_stb & bus.inp_rdy;
    assign arg_ack = bus.arg_stb & bus.arg_rdy;
    assign dlt_ack = bus.dlt_stb & bus.dlt_rdy;

    // Forward MAC term: signed weight times zero-extended activation.
    logic signed [24:0] mac_prod;
    logic signed [31:0] mac_ext;
    assign mac_prod = w_q[adr] * $signed({1'b0, bus.inp_dat});
    assign mac_ext  = $signed({{7{mac_prod[24]}}, mac_prod});

    // Weight step: (dlt * x) >>> (8 + RATE); magnitude always fits 18 bits.
    logic signed [24:0] upd_prod;
    logic signed [24:0] upd_shift;
    logic signed [17:0] w_ext, w_inc, w_sum;
    assign upd_prod  = dlt_q * $signed({1'b0, x_q[adr]});
    assign upd_shift = upd_prod >>> (8 + RATE);
    assign w_ext     = $signed({{2{w_q[adr][15]}}, w_q[adr]});
    assign w_inc     = upd_shift[17:0];
    assign w_sum     = w_ext + w_inc;

    // Bias step: dlt >>> RATE.
    logic signed [17:0] b_ext, dlt_ext, b_inc, b_sum;
    assign b_ext   = $signed({{2{b_q[15]}}, b_q});
    assign dlt_ext = $signed({{2{dlt_q[15]}}, dlt_q});
    assign b_inc   = dlt_ext >>> RATE;
    assign b_sum   = b_ext + b_inc;

    // Bits that carry no information once the values are known to fit.
    logic unused_bits;
    assign unused_bits = ^{upd_shift[24:18], w_sum[17:16], b_sum[17:16]};

    // Output conversion of acc >>> 8 to Q8.8.
    logic [15:0] arg_val;
`ifdef NEURON_SATURATE_EN
    logic signed [23:0] acc_sh;
    assign acc_sh = acc_q[31:8];
    // Clamp the shifted accumulator into the signed 16-bit range.
    always_comb begin
        if (acc_sh > 24'sd32767) begin
            arg_val = 16'h7FFF;
        end else if (acc_sh < -24'sd32768) begin
            arg_val = 16'h8000;
        end else begin
            arg_val = acc_sh[15:0];
        end
    end
`else
    assign arg_val = acc_q[23:8];
`endif

    assign bus.inp_rdy = (state_q == StIn);
    assign bus.arg_stb = (state_q == StArg);
    assign bus.dlt_rdy = (state_q == StDlt);
    assign bus.arg_dat = arg_val;

    // Next-state logic: sample collection, output, delta capture, update sweep.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        w_d     = w_q;
        b_d     = b_q;
        x_d     = x_q;
        dlt_d   = dlt_q;
        case (state_q)
            StIn: begin
                if (inp_ack) begin
                    x_d[adr] = bus.inp_dat;
                    acc_d    = acc_q + mac_ext;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StArg;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
            end
            StArg: begin
                if (arg_ack) begin
                    if (en_i) begin
                        state_d = StDlt;
                    end else begin
                        acc_d   = $signed({{8{b_q[15]}}, b_q, 8'h00});
                        state_d = StIn;
                    end
                end
            end
            StDlt: begin
                if (dlt_ack) begin
                    dlt_d   = $signed(bus.dlt_dat);
                    state_d = StUpd;
                end
            end
            StUpd: begin
                if (idx_q != BiasIdx) begin
                    w_d[adr] = upd_fn(w_sum);
                    idx_d    = idx_q + IdxOne;
                end else begin
                    b_d     = upd_fn(b_sum);
                    // Next sample starts from the freshly updated bias.
                    acc_d   = $signed({{8{b_d[15]}}, b_d, 8'h00});
                    idx_d   = '0;
                    state_d = StIn;
                end
            end
            default: begin
                state_d = StIn;
                idx_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIn;
            idx_q   <= '0;
            acc_q   <= '0;
            w_q     <= '{default: '0};
            b_q     <= '0;
            x_q     <= '{default: '0};
            dlt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
            b_q     <= b_d;
            x_q     <= x_d;
            dlt_q   <= dlt_d;
        end
    end

endmodule
